btn_debounce: RTL and testbench
===============================

# btn_debounce

Multi-channel push-button conditioner that sits directly upstream of the LED counter logic inside `top_counter`. It synchronises raw board buttons into the 100 MHz `clk` domain and filters contact bounce with a per-channel stability counter. It presents a clean level plus single-cycle press and release strobes. The counter stage consumes these outputs for pause, step and direction control.

## Interface
- `C_NUM_BTN`, default 4: number of independent button channels (btnU, btnL, btnR, btnD order, bit 0 = btnU).
- `C_DEBOUNCE_COUNT`, default 1_000_000: cycles a synchronised input must hold a new value before it is accepted (10 ms at 100 MHz). Legal range ≥ 2. Benches override it to 100.

Ports:
- `clk`  input  1: 100 MHz system clock; all logic on the rising edge.
- `btnC`  input  1: synchronous, active-high reset.
- `btn_in`  input  C_NUM_BTN: raw asynchronous button inputs, active-high.
- `btn_level`  output  C_NUM_BTN: debounced button state.
- `btn_press`  output  C_NUM_BTN: one-cycle strobe when `btn_level` bit goes 0→1.
- `btn_release`  output  C_NUM_BTN: one-cycle strobe when `btn_level` bit goes 1→0.

## Operation
- Per channel: a 2-FF synchroniser `btn_in` → `s1` → `s`. Nothing but the synchroniser samples `btn_in`.
- Per channel: a 4-state FSM plus a stability counter `cnt`, width `$clog2(C_DEBOUNCE_COUNT)`.
  - IDLE_LOW: `btn_level`=0. If `s`=1, go to WAIT_HIGH with `cnt`=0.
  - WAIT_HIGH: `btn_level`=0.
    - If `s`=0, go to IDLE_LOW with `cnt`=0, no strobe (bounce rejected).
    - Else if `cnt`==C_DEBOUNCE_COUNT−1, go to IDLE_HIGH, assert `btn_press` for this one cycle, `cnt`=0.
    - Else `cnt`++.
  - IDLE_HIGH: `btn_level`=1. If `s`=0, go to WAIT_LOW with `cnt`=0.
  - WAIT_LOW: the mirror of WAIT_HIGH.
    - If `s`=1, go to IDLE_HIGH with `cnt`=0.
    - Else if `cnt`==C_DEBOUNCE_COUNT−1, go to IDLE_LOW, assert `btn_release` for this one cycle.
    - Else `cnt`++.
- `btn_level` is 1 exactly in IDLE_HIGH and WAIT_LOW, i.e. it holds its old value while a change is pending.
- All outputs are registered. No combinational path exists from `btn_in` to any output.
- Channels are fully independent. Simultaneous activity on several channels yields simultaneous strobes in the same cycle where the timing coincides.
- `cnt` never exceeds C_DEBOUNCE_COUNT−1 and never wraps.
- `btn_press` and `btn_release` are never both high on the same channel in the same cycle.
- Each strobe is followed by at least C_DEBOUNCE_COUNT+1 cycles before the next strobe on the same channel.

## Timing
- Reset (`btnC`=1 at a rising edge): `s1`, `s` = 0; FSM = IDLE_LOW; `cnt` = 0; `btn_level`, `btn_press`, `btn_release` = 0 from the next cycle. Reset has priority over every transition.
- Reset mid-operation: any pending WAIT state is abandoned with no strobe. A button still held after reset deasserts is re-debounced from scratch and produces a `btn_press` at the normal latency.
- Acceptance latency: `btn_in` changes before edge 1 and stays stable. Then `s` updates at edge 2, the FSM enters WAIT at edge 3, and `btn_level` and the strobe update at edge 3+C_DEBOUNCE_COUNT.
- Rejection: a synchronised glitch shorter than C_DEBOUNCE_COUNT+1 sampled cycles never changes `btn_level`. The counter restarts at 0 on every re-entry to a WAIT state.
- Strobes are exactly 1 cycle wide and coincide with the `btn_level` transition cycle.

## Test plan
All scenarios use C_DEBOUNCE_COUNT=100 and C_NUM_BTN=4.
- Reset: hold `btnC`=1 for 20 cycles while `btn_in`=4'b1111 → all outputs are 0 throughout. After release, `btn_level`=4'b1111 with a single `btn_press`=4'b1111 pulse exactly 103 cycles after the first non-reset edge.
- Clean press and release on bit 0: `btn_in[0]` rises → `btn_level[0]` goes high and `btn_press[0]` pulses once, 103 cycles after the change. On release, `btn_level[0]` falls and `btn_release[0]` pulses once, 103 cycles later.
- Bounce rejection: toggle `btn_in[1]` with high periods of 50 cycles and low periods of 30 cycles, 10 times → `btn_level[1]` stays 0 with no strobes. Then hold it high → one `btn_press[1]` 103 cycles after the last rising edge.
- Boundary: a synchronised high pulse of exactly 100 cycles → rejected. A pulse of 101 cycles → accepted, with `btn_level` staying high until the release has itself debounced.
- Simultaneous: `btn_in[2]` and `btn_in[3]` rise on the same cycle → `btn_press[3:2]`=2'b11 on the same single cycle, with bits 0 and 1 unaffected.
- Reset mid-wait: assert `btnC` 50 cycles into WAIT_HIGH on bit 0 → no strobe is emitted. Timing restarts, so `btn_press[0]` comes 103 cycles after reset deasserts.

Source files
------------

// File: rtl/btn_debounce.sv
// Per-channel push-button conditioner: 2-FF synchroniser followed by a
// stability-counter FSM giving a debounced level and one-cycle press/release strobes.
`timescale 1ns/1ps
module btn_debounce #(
    parameter int C_NUM_BTN        = 4,
    parameter int C_DEBOUNCE_COUNT = 1_000_000
) (
    input  logic                   clk,
    input  logic                   btnC,
    input  logic [C_NUM_BTN-1:0]   btn_in,
    output logic [C_NUM_BTN-1:0]   btn_level,
    output logic [C_NUM_BTN-1:0]   btn_press,
    output logic [C_NUM_BTN-1:0]   btn_release,
    // 2 bits per channel: 0 IDLE_LOW, 1 WAIT_HIGH, 2 IDLE_HIGH, 3 WAIT_LOW
    output logic [2*C_NUM_BTN-1:0] dbg_state
);

    localparam int            CW      = $clog2(C_DEBOUNCE_COUNT);
    localparam logic [CW-1:0] CNT_MAX = CW'(C_DEBOUNCE_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [C_NUM_BTN-1:0] s1;
    logic [C_NUM_BTN-1:0] s;

    // The only flops that ever sample the asynchronous button pins.
    always_ff @(posedge clk) begin
        if (btnC) begin
            s1 <= '0;
            s  <= '0;
        end else begin
            s1 <= btn_in;
            s  <= s1;
        end
    end

    for (genvar i = 0; i < C_NUM_BTN; i++) begin : g_ch
        state_t        state;
        state_t        state_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          press_q;
        logic          press_nxt;
        logic          release_q;
        logic          release_nxt;

        always_ff @(posedge clk) begin
            if (btnC) begin
                state     <= IDLE_LOW;
                cnt       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
            end
        end

        // Counter restarts on every WAIT entry, so a glitch must be absent
        // for a full window before it is forgiven and re-timed.
        always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (s[i]) begin
                        state_nxt = WAIT_HIGH;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!s[i]) begin
                        state_nxt = IDLE_LOW;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = IDLE_HIGH;
                        press_nxt = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!s[i]) begin
                        state_nxt = WAIT_LOW;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_LOW: begin
                    if (s[i]) begin
                        state_nxt = IDLE_HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt   = IDLE_LOW;
                        release_nxt = 1'b1;
                        cnt_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Level is decoded from the state register, so it keeps its old
        // value while a change is still being qualified.
        assign btn_level[i]        = (state == IDLE_HIGH) || (state == WAIT_LOW);
        assign btn_press[i]        = press_q;
        assign btn_release[i]      = release_q;
        assign dbg_state[2*i +: 2] = state;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: strobe scoreboard keyed on cycle number,
// table of pulse-length vectors, and hand sequences for reset and bounce cases.
`timescale 1ns/1ps
module tb_btn_debounce;

    localparam int NB  = 4;
    localparam int DC  = 100;
    localparam int LAT = DC + 3;

    logic            clk = 1'b0;
    logic            btnC;
    logic [NB-1:0]   btn_in;
    logic [NB-1:0]   btn_level;
    logic [NB-1:0]   btn_press;
    logic [NB-1:0]   btn_release;
    logic [2*NB-1:0] dbg_state;

    int          cyc       = 0;
    int          tests_run = 0;
    int          fails     = 0;
    logic [39:0] exp_q[$];

    typedef struct packed {
        logic [3:0]  ch;
        logic [15:0] high_len;
        logic        accept;
    } pulse_vec_t;

    pulse_vec_t vecs [7];

    btn_debounce #(
        .C_NUM_BTN        (NB),
        .C_DEBOUNCE_COUNT (DC)
    ) dut (
        .clk         (clk),
        .btnC        (btnC),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .dbg_state   (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every strobe must match the next expected {cycle, press, release}.
    always @(negedge clk) begin
        if (cyc > 1 && (btn_press | btn_release) != '0) begin
            if (exp_q.size() == 0)
                check("unexpected_strobe", {32'(cyc), btn_press, btn_release}, 40'd0);
            else
                check("strobe", {32'(cyc), btn_press, btn_release}, exp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_evt(input int at, input logic [NB-1:0] p, input logic [NB-1:0] r);
        exp_q.push_back({32'(at), p, r});
    endtask

    task automatic wait_events(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("events_drained", 40'(exp_q.size()), 40'd0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("reset_outputs", 40'({btn_level, btn_press, btn_release}), 40'd0);
    endtask

    initial begin
        int k;
        int k2;
        int r;
        int ch;
        int len;
        logic acc;
        logic [NB-1:0] m;

        vecs[0] = '{ch: 4'd0, high_len: 16'd300, accept: 1'b1};
        vecs[1] = '{ch: 4'd0, high_len: 16'd100, accept: 1'b0};
        vecs[2] = '{ch: 4'd0, high_len: 16'd101, accept: 1'b1};
        vecs[3] = '{ch: 4'd2, high_len: 16'd99,  accept: 1'b0};
        vecs[4] = '{ch: 4'd3, high_len: 16'd150, accept: 1'b1};
        vecs[5] = '{ch: 4'd1, high_len: 16'd2,   accept: 1'b0};
        vecs[6] = '{ch: 4'd1, high_len: 16'd1,   accept: 1'b0};

        // Reset held with all buttons pressed
        btnC   = 1'b1;
        btn_in = '1;
        for (int i = 0; i < 20; i++) begin
            step();
            check_reset_outputs();
            check("reset_state", 40'(dbg_state), 40'd0);
        end
        btnC = 1'b0;
        expect_evt(cyc + LAT, 4'hF, 4'h0);
        wait_events(150);
        check("level_after_reset", 40'(btn_level), 40'(4'hF));

        btn_in = '0;
        expect_evt(cyc + LAT, 4'h0, 4'hF);
        wait_events(150);
        check("level_all_released", 40'(btn_level), 40'd0);

        // Table-driven pulse lengths
        for (int v = 0; v < 7; v++) begin
            ch  = int'(vecs[v].ch);
            len = int'(vecs[v].high_len);
            acc = vecs[v].accept;
            m   = NB'(1) << ch;
            k   = cyc;
            btn_in[ch] = 1'b1;
            if (acc) expect_evt(k + LAT, m, '0);
            repeat (len) step();
            k2 = cyc;
            check("level_at_drop", 40'(btn_level[ch]), 40'((acc && len >= LAT) ? 1 : 0));
            btn_in[ch] = 1'b0;
            if (acc) expect_evt(k2 + LAT, '0, m);
            repeat (LAT - 1) step();
            check("level_hold", 40'(btn_level[ch]), 40'(acc));
            repeat (10) step();
            check("level_end", 40'(btn_level), 40'd0);
            check("queue_empty", 40'(exp_q.size()), 40'd0);
        end

        // Bounce on bit 1, then a stable press
        for (int b = 0; b < 10; b++) begin
            btn_in[1] = 1'b1;
            repeat (50) step();
            btn_in[1] = 1'b0;
            repeat (30) step();
        end
        check("bounce_level", 40'(btn_level), 40'd0);
        k = cyc;
        btn_in[1] = 1'b1;
        expect_evt(k + LAT, 4'b0010, 4'b0000);
        wait_events(150);
        check("bounce_final_level", 40'(btn_level), 40'(4'b0010));
        btn_in[1] = 1'b0;
        expect_evt(cyc + LAT, 4'b0000, 4'b0010);
        wait_events(150);

        // Simultaneous press on bits 2 and 3
        btn_in = 4'b1100;
        expect_evt(cyc + LAT, 4'b1100, 4'b0000);
        wait_events(150);
        check("simul_level", 40'(btn_level), 40'(4'b1100));
        btn_in = 4'b0000;
        expect_evt(cyc + LAT, 4'b0000, 4'b1100);
        wait_events(150);
        check("simul_released", 40'(btn_level), 40'd0);

        // Reset 50 cycles into WAIT_HIGH on bit 0
        k = cyc;
        btn_in = 4'b0001;
        repeat (53) step();
        check("mid_wait_state", 40'(dbg_state[1:0]), 40'd1);
        btnC = 1'b1;
        repeat (3) begin
            step();
            check_reset_outputs();
        end
        btnC = 1'b0;
        r = cyc;
        expect_evt(r + LAT, 4'b0001, 4'b0000);
        wait_events(150);
        check("post_reset_level", 40'(btn_level), 40'(4'b0001));
        btn_in = 4'b0000;
        expect_evt(cyc + LAT, 4'b0000, 4'b0001);
        wait_events(150);
        check("final_level", 40'(btn_level), 40'd0);

        // Report
        repeat (5) step();
        check("queue_empty_end", 40'(exp_q.size()), 40'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
